collatz_sweep_ctrl: RTL and testbench

Sweep controller for the Collatz orbit engine. It accepts a starting seed, a seed count and a stride mode from the host I/O logic. It launches the engine on each seed in turn over a start/done handshake and keeps the longest orbit length seen, together with the seed that produced it. A watchdog recovers from an engine that never finishes, for example on seed 0.

---
 rtl/collatz_sweep_ctrl_if.sv | 14 +
 rtl/collatz_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_collatz_sweep_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/collatz_sweep_ctrl_if.sv
// Launch/kill/completion bus between the sweep controller and the Collatz orbit engine.
interface collatz_sweep_ctrl_if #(
  parameter int SEED_BITS = 32,
  parameter int OLEN_BITS = 16
);
  logic                 core_start;
  logic [SEED_BITS-1:0] core_seed;
  logic                 core_kill;
  logic                 core_done;
  logic [OLEN_BITS-1:0] core_orbit_len;

  modport master (output core_start, core_seed, core_kill, input  core_done, core_orbit_len);
  modport slave  (input  core_start, core_seed, core_kill, output core_done, core_orbit_len);
endinterface

// File: rtl/collatz_sweep_ctrl.sv
// Sweeps a run of seeds through the Collatz engine, tracking the longest orbit and its seed.
// A watchdog kills the engine when one seed takes too long (e.g. seed 0 never reaches 1).
module collatz_sweep_ctrl #(
  parameter int SEED_BITS  = 32,
  parameter int COUNT_BITS = 16,
  parameter int OLEN_BITS  = 16,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEED_BITS-1:0]  cfg_seed,
  input  logic [COUNT_BITS-1:0] cfg_count,
  input  logic                  cfg_odd_only,
  input  logic                  go,
  input  logic                  abort,
  collatz_sweep_ctrl_if.master  core,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic [OLEN_BITS-1:0]  best_len,
  output logic [SEED_BITS-1:0]  best_seed,
  output logic [COUNT_BITS-1:0] seeds_done
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, UPDATE} state_t;

  state_t                state;
  logic                  start_q, kill_q, odd_q;
  logic [SEED_BITS-1:0]  seed_q;
  logic [COUNT_BITS-1:0] count_q;
  logic [OLEN_BITS-1:0]  len_q;
  logic [WD_W-1:0]       wdog;
  logic [COUNT_BITS-1:0] done_nxt;
  logic [SEED_BITS-1:0]  seed_nxt;

  assign core.core_start = start_q;
  assign core.core_seed  = seed_q;
  assign core.core_kill  = kill_q;

  always_comb begin
    done_nxt = seeds_done + COUNT_BITS'(1);
    seed_nxt = seed_q + (odd_q ? SEED_BITS'(2) : SEED_BITS'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      kill_q      <= 1'b0;
      odd_q       <= 1'b0;
      seed_q      <= '0;
      count_q     <= '0;
      len_q       <= '0;
      wdog        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      best_len    <= '0;
      best_seed   <= '0;
      seeds_done  <= '0;
    end else begin
      start_q <= 1'b0;
      kill_q  <= 1'b0;
      // abort outranks every in-flight event; partial results stay visible
      if (abort && state != IDLE) begin
        state  <= IDLE;
        busy   <= 1'b0;
        kill_q <= (state == LAUNCH) || (state == WAIT);
      end else begin
        case (state)
          IDLE: if (go && !abort) begin
            seed_q      <= cfg_odd_only ? (cfg_seed | SEED_BITS'(1)) : cfg_seed;
            count_q     <= cfg_count;
            odd_q       <= cfg_odd_only;
            best_len    <= '0;
            best_seed   <= '0;
            seeds_done  <= '0;
            err_timeout <= 1'b0;
            if (cfg_count == '0) begin
              done <= 1'b1;
            end else begin
              done    <= 1'b0;
              state   <= LAUNCH;
              busy    <= 1'b1;
              start_q <= 1'b1;
            end
          end
          LAUNCH: begin
            state <= WAIT;
            wdog  <= '0;
          end
          WAIT: begin
            if (core.core_done) begin
              len_q <= core.core_orbit_len;
              state <= UPDATE;
            end else if (wdog == WD_W'(TIMEOUT - 1)) begin
              kill_q      <= 1'b1;
              err_timeout <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              wdog <= wdog + WD_W'(1);
            end
          end
          UPDATE: begin
            // strict compare: ties keep the earlier seed
            if (len_q > best_len) begin
              best_len  <= len_q;
              best_seed <= seed_q;
            end
            seeds_done <= done_nxt;
            seed_q     <= seed_nxt;
            if (done_nxt == count_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              start_q <= 1'b1;
              state   <= LAUNCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_collatz_sweep_ctrl.sv
// Directed bench for collatz_sweep_ctrl with a behavioural engine of random 1..20 cycle latency.
module tb_collatz_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_seed = '0;
  logic [15:0] cfg_count = '0;
  logic        cfg_odd_only = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, err_timeout;
  logic [15:0] best_len, seeds_done;
  logic [31:0] best_seed;

  int errors = 0;
  int checks = 0;

  // engine model: 0 = true Collatz length, 1 = fixed length, 2 = never completes
  int          eng_mode = 0;
  logic [15:0] eng_fixed = '0;
  logic        eng_busy = 1'b0;
  int          eng_cnt = 0;
  logic [31:0] eng_seed = '0;
  logic [31:0] starts[$];

  collatz_sweep_ctrl_if #(.SEED_BITS(32), .OLEN_BITS(16)) bus ();

  collatz_sweep_ctrl #(.SEED_BITS(32), .COUNT_BITS(16), .OLEN_BITS(16), .TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_seed(cfg_seed), .cfg_count(cfg_count),
    .cfg_odd_only(cfg_odd_only), .go(go), .abort(abort), .core(bus.master),
    .busy(busy), .done(done), .err_timeout(err_timeout), .best_len(best_len),
    .best_seed(best_seed), .seeds_done(seeds_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] collatz_len(input logic [31:0] s);
    logic [63:0] n;
    logic [15:0] k;
    n = {32'd0, s};
    k = 0;
    while (n > 1) begin
      n = n[0] ? (3 * n + 1) : (n >> 1);
      k++;
    end
    return k;
  endfunction

  always @(negedge clk) begin
    bus.core_done = 1'b0;
    if (!rst_n || bus.core_kill) begin
      eng_busy = 1'b0;
    end else if (bus.core_start) begin
      eng_busy = 1'b1;
      eng_cnt  = $urandom_range(20, 1);
      eng_seed = bus.core_seed;
      starts.push_back(bus.core_seed);
    end else if (eng_busy && eng_mode != 2 && !(eng_mode == 0 && eng_seed == 0)) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_busy           = 1'b0;
        bus.core_done      = 1'b1;
        bus.core_orbit_len = (eng_mode == 1) ? eng_fixed : collatz_len(eng_seed);
      end
    end
  end

  initial begin
    bus.core_done      = 1'b0;
    bus.core_orbit_len = '0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input logic [31:0] s, input logic [15:0] n, input logic odd,
                           output logic b1, output logic s1);
    starts.delete();
    cfg_seed = s; cfg_count = n; cfg_odd_only = odd;
    go = 1'b1;
    tick;
    go = 1'b0;
    b1 = busy;
    s1 = bus.core_start;
    for (int i = 0; i < 3000 && busy; i++) tick;
    check("sweep_timeout", busy, 0);
  endtask

  initial begin
    logic b1, s1, hit;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_best", {best_len, best_seed, seeds_done}, 0);
    check("rst_core", {bus.core_start, bus.core_kill, bus.core_seed}, 0);

    // 1: seeds 1..10, seed 9 has the longest orbit (19)
    run_sweep(32'd1, 16'd10, 1'b0, b1, s1);
    check("t1_busy_t1", b1, 1);
    check("t1_start_t1", s1, 1);
    check("t1_nstarts", starts.size(), 10);
    for (int i = 0; i < 10; i++)
      check("t1_seed_order", (i < starts.size()) ? starts[i] : 32'hDEAD, i + 1);
    check("t1_best_seed", best_seed, 9);
    check("t1_best_len", best_len, 19);
    check("t1_seeds_done", seeds_done, 10);
    check("t1_done", done, 1);

    // 2: odd-only from 2 -> 3,5,7,9; then all-equal lengths keep the first seed
    run_sweep(32'd2, 16'd4, 1'b1, b1, s1);
    check("t2_nstarts", starts.size(), 4);
    check("t2_seeds", (starts.size() == 4) ? {starts[0][7:0], starts[1][7:0], starts[2][7:0], starts[3][7:0]} : 0,
          32'h03050709);
    check("t2_best_seed", best_seed, 9);
    check("t2_best_len", best_len, 19);
    eng_mode = 1; eng_fixed = 16'd7;
    run_sweep(32'd2, 16'd4, 1'b1, b1, s1);
    check("t2_tie_seed", best_seed, 3);
    check("t2_tie_len", best_len, 7);
    eng_mode = 0;

    // 3: zero count finishes immediately
    run_sweep(32'd5, 16'd0, 1'b0, b1, s1);
    check("t3_busy", b1, 0);
    check("t3_start", s1, 0);
    check("t3_done", done, 1);
    tick;
    check("t3_nstarts", starts.size(), 0);

    // 4: watchdog on a hung engine, TIMEOUT = 50
    eng_mode = 2;
    cfg_seed = 32'd5; cfg_count = 16'd3; cfg_odd_only = 1'b0;
    go = 1'b1; tick; go = 1'b0;
    repeat (50) tick;
    check("t4_kill_early", bus.core_kill, 0);
    check("t4_busy_wait", busy, 1);
    tick;
    check("t4_kill", bus.core_kill, 1);
    check("t4_err", err_timeout, 1);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    tick;
    check("t4_kill_pulse", bus.core_kill, 0);
    eng_mode = 0;
    run_sweep(32'd5, 16'd0, 1'b0, b1, s1);
    check("t4_err_clr", err_timeout, 0);

    // 5: abort in WAIT of seed 3
    cfg_seed = 32'd1; cfg_count = 16'd10; cfg_odd_only = 1'b0;
    go = 1'b1; tick; go = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      if (bus.core_start && bus.core_seed == 32'd3) hit = 1'b1;
      else tick;
    end
    check("t5_reach_seed3", hit, 1);
    eng_mode = 2;
    tick;
    abort = 1'b1; tick; abort = 1'b0;
    check("t5_kill", bus.core_kill, 1);
    check("t5_busy", busy, 0);
    check("t5_seeds_done", seeds_done, 2);
    check("t5_done", done, 0);
    check("t5_best", {best_seed, best_len}, {32'd2, 16'd1});
    eng_mode = 0;
    go = 1'b1; abort = 1'b1; tick; go = 1'b0; abort = 1'b0;
    check("t5_goabort_busy", busy, 0);
    check("t5_goabort_start", bus.core_start, 0);
    check("t5_goabort_keep", seeds_done, 2);

    // 6: seed wrap, then go and reset mid-sweep
    eng_mode = 1; eng_fixed = 16'd5;
    run_sweep(32'hFFFF_FFFF, 16'd2, 1'b0, b1, s1);
    check("t6_nstarts", starts.size(), 2);
    check("t6_seed0", (starts.size() > 0) ? starts[0] : 0, 32'hFFFF_FFFF);
    check("t6_seed1", (starts.size() > 1) ? starts[1] : 32'hDEAD, 0);
    check("t6_best_seed", best_seed, 32'hFFFF_FFFF);
    check("t6_best_len", best_len, 5);
    check("t6_done", done, 1);
    cfg_seed = 32'd100; cfg_count = 16'd10;
    go = 1'b1; tick; go = 1'b0;
    for (int i = 0; i < 500 && seeds_done < 3; i++) tick;
    check("t6_progress", seeds_done >= 3, 1);
    cfg_count = 16'd0;
    go = 1'b1; tick; go = 1'b0;
    check("t6_go_ign_busy", busy, 1);
    check("t6_go_ign_done", done, 0);
    check("t6_go_ign_keep", seeds_done >= 3, 1);
    rst_n = 1'b0; tick;
    check("t6_rst_flags", {busy, done, err_timeout}, 0);
    check("t6_rst_best", {best_len, best_seed, seeds_done}, 0);
    check("t6_rst_core", {bus.core_start, bus.core_kill, bus.core_seed}, 0);
    rst_n = 1'b1;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
